// File: rtl/tpu_instr_receiver.sv
// TPU-side endpoint of the MPU issue/commit interface: buffers a thread, feeds the sequencer, commits the issue number.
// Optional issue-sequence check enabled by defining TPU_RX_SEQCHK_EN.
module tpu_instr_receiver #(
    parameter int WIDTH_INSTR = 32,
    parameter int WIDTH_ISSUE = 4,
    parameter int WIDTH_LEN   = 8,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   I_Req,
    input  logic [WIDTH_INSTR-1:0] I_Instr,
    input  logic [WIDTH_ISSUE-1:0] I_IssueNo,
    output logic                   O_Req_Exe,
    output logic [WIDTH_INSTR-1:0] O_Instr_Exe,
    input  logic                   I_Ack_Exe,
    input  logic                   I_End_Exe,
    output logic                   O_Req_Commit,
    output logic [WIDTH_ISSUE-1:0] O_CommitNo,
    output logic                   O_Busy,
    output logic [1:0]             O_Err,
    output logic [1:0]             state_dbg
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, RECV, DRAIN, COMMIT} state_t;
    state_t state, state_next;

    logic [WIDTH_INSTR-1:0] mem [FIFO_DEPTH];
    logic [AW:0]            wr_ptr, rd_ptr;
    logic [WIDTH_LEN-1:0]   remaining;
    logic [WIDTH_ISSUE-1:0] issue_no, commit_no;
    logic                   end_seen, commit_req, err_proto, err_seq;
    logic                   empty, full, pop, push_req, push, overflow, hdr_accept, hdr_busy;

    // Sequencer handshake: O_Req_Exe is valid while the FIFO holds a word; the head
    // is consumed on any cycle where O_Req_Exe and I_Ack_Exe are both high.
    assign empty      = (wr_ptr == rd_ptr);
    assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop        = !empty && I_Ack_Exe;
    assign hdr_accept = (state == IDLE) && I_Req;
    assign push_req   = (state == RECV) && I_Req;
    assign push       = push_req && (!full || pop);
    assign overflow   = push_req && full && !pop;
    assign hdr_busy   = I_Req && ((state == DRAIN) || (state == COMMIT));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (I_Req) state_next = (I_Instr[WIDTH_LEN-1:0] == '0) ? COMMIT : RECV;
            RECV:    if (I_Req && remaining == WIDTH_LEN'(1)) state_next = DRAIN;
            DRAIN:   if (empty && end_seen) state_next = COMMIT;
            COMMIT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Storage is not reset; flushing is done by clearing the pointers.
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr[AW-1:0]] <= I_Instr;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            remaining  <= '0;
            issue_no   <= '0;
            end_seen   <= 1'b0;
            commit_req <= 1'b0;
            commit_no  <= '0;
            err_proto  <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (hdr_accept) begin
                remaining <= I_Instr[WIDTH_LEN-1:0];
                issue_no  <= I_IssueNo;
            end else if (push_req) begin
                remaining <= remaining - 1'b1;
            end
            // An end pulse arriving before the FIFO drains is remembered here.
            if (state == COMMIT)
                end_seen <= 1'b0;
            else if (I_End_Exe && ((state == RECV) || (state == DRAIN)))
                end_seen <= 1'b1;
            commit_req <= (state == COMMIT);
            if (state == COMMIT) commit_no <= issue_no;
            if (overflow || hdr_busy) err_proto <= 1'b1;
        end
    end

`ifdef TPU_RX_SEQCHK_EN
    logic have_prev;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            have_prev <= 1'b0;
            err_seq   <= 1'b0;
        end else if (hdr_accept) begin
            have_prev <= 1'b1;
            if (have_prev && (I_IssueNo != issue_no + WIDTH_ISSUE'(1))) err_seq <= 1'b1;
        end
    end
`else
    assign err_seq = 1'b0;
`endif

    assign O_Req_Exe    = !empty;
    assign O_Instr_Exe  = empty ? '0 : mem[rd_ptr[AW-1:0]];
    assign O_Req_Commit = commit_req;
    assign O_CommitNo   = commit_no;
    // Busy also covers the commit pulse cycle so it drops only after the commit is out.
    assign O_Busy       = (state != IDLE) || commit_req;
    assign O_Err        = {err_seq, err_proto};
    assign state_dbg    = state;
endmodule

// File: tb/tb_tpu_instr_receiver.sv
// Directed bench for tpu_instr_receiver: thread-level model checked every cycle plus literal expectations.
module tb_tpu_instr_receiver;
    logic        clock = 1'b0;
    logic        reset;
    logic        I_Req, I_Ack_Exe, I_End_Exe;
    logic [31:0] I_Instr;
    logic [3:0]  I_IssueNo;
    logic        O_Req_Exe, O_Req_Commit, O_Busy;
    logic [31:0] O_Instr_Exe;
    logic [3:0]  O_CommitNo;
    logic [1:0]  O_Err, state_dbg;

    int checks = 0;
    int failures = 0;

`ifdef TPU_RX_SEQCHK_EN
    localparam bit SEQ_EN = 1'b1;
`else
    localparam bit SEQ_EN = 1'b0;
`endif

    tpu_instr_receiver dut (
        .clock(clock), .reset(reset), .I_Req(I_Req), .I_Instr(I_Instr), .I_IssueNo(I_IssueNo),
        .O_Req_Exe(O_Req_Exe), .O_Instr_Exe(O_Instr_Exe), .I_Ack_Exe(I_Ack_Exe), .I_End_Exe(I_End_Exe),
        .O_Req_Commit(O_Req_Commit), .O_CommitNo(O_CommitNo), .O_Busy(O_Busy), .O_Err(O_Err),
        .state_dbg(state_dbg)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Thread-level model: a word queue plus counters for the thread in flight.
    logic [31:0] m_fifo[$];
    bit          m_active, m_due, m_end, m_pulse, m_have_prev;
    bit          m_pop, m_push, m_new_pulse;
    int          m_rem;
    logic [3:0]  m_issue, m_cno;
    logic [1:0]  m_err;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_fifo.delete();
            m_active = 0; m_due = 0; m_end = 0; m_pulse = 0; m_have_prev = 0;
            m_rem = 0; m_issue = 0; m_cno = 0; m_err = 0;
        end else begin
            m_pop = (m_fifo.size() != 0) && I_Ack_Exe;
            m_push = 0;
            m_new_pulse = 0;
            if (m_active && m_due) begin
                m_new_pulse = 1; m_cno = m_issue; m_active = 0; m_due = 0; m_end = 0;
                if (I_Req) m_err[0] = 1;
            end else if (m_active && m_rem > 0) begin
                if (I_End_Exe) m_end = 1;
                if (I_Req) begin
                    if (m_fifo.size() < 16 || m_pop) m_push = 1;
                    else m_err[0] = 1;
                    m_rem--;
                end
            end else if (m_active) begin
                if (m_fifo.size() == 0 && m_end) m_due = 1;
                if (I_End_Exe) m_end = 1;
                if (I_Req) m_err[0] = 1;
            end else if (I_Req) begin
                if (SEQ_EN && m_have_prev && I_IssueNo != 4'(m_issue + 4'd1)) m_err[1] = 1;
                m_have_prev = 1;
                m_rem = int'(I_Instr[7:0]);
                m_issue = I_IssueNo;
                m_active = 1;
                m_due = (m_rem == 0);
            end
            if (m_pop) void'(m_fifo.pop_front());
            if (m_push) m_fifo.push_back(I_Instr);
            m_pulse = m_new_pulse;
        end
    end

    always @(negedge clock) begin
        if (!reset) begin
            check("exe_valid", O_Req_Exe, m_fifo.size() != 0);
            check("exe_instr", O_Instr_Exe, (m_fifo.size() != 0) ? m_fifo[0] : 32'h0);
            check("commit_req", O_Req_Commit, m_pulse);
            check("commit_no", O_CommitNo, m_cno);
            check("busy", O_Busy, m_active || m_pulse);
            check("err", O_Err, m_err);
        end
    end

    // Observed traffic, used by the literal expectations.
    logic [31:0] deliv_q[$];
    int          commit_cnt = 0;
    int          exe_cnt = 0;
    logic [3:0]  last_cno = 0;

    always @(posedge clock) begin
        if (!reset) begin
            if (O_Req_Exe && I_Ack_Exe) deliv_q.push_back(O_Instr_Exe);
            if (O_Req_Exe) exe_cnt++;
            if (O_Req_Commit) begin
                commit_cnt++;
                last_cno = O_CommitNo;
            end
        end
    end

    task automatic drive(input bit req, input logic [31:0] instr, input logic [3:0] issue);
        I_Req = req; I_Instr = instr; I_IssueNo = issue;
        @(negedge clock);
    endtask

    task automatic idle(input int n);
        I_Req = 0; I_Instr = 0; I_IssueNo = 0;
        repeat (n) @(negedge clock);
    endtask

    task automatic pulse_end();
        I_End_Exe = 1;
        @(negedge clock);
        I_End_Exe = 0;
    endtask

    task automatic wait_commits(input int target, input int budget, input string name);
        for (int i = 0; i < budget && commit_cnt < target; i++) @(negedge clock);
        check(name, commit_cnt, target);
    endtask

    task automatic do_reset();
        reset = 1; I_Req = 0; I_Ack_Exe = 0; I_End_Exe = 0;
        @(negedge clock);
        reset = 0;
    endtask

    initial begin
        #100000;
        failures++;
        $display("FAIL watchdog expired");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        logic [31:0] w3[3];
        int c0, e0;
        w3 = '{32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003};
        reset = 1; I_Req = 0; I_Instr = 0; I_IssueNo = 0; I_Ack_Exe = 0; I_End_Exe = 0;
        @(negedge clock);
        check("rst_exe", O_Req_Exe, 1'b0);
        check("rst_instr", O_Instr_Exe, 32'h0);
        check("rst_commit", O_Req_Commit, 1'b0);
        check("rst_busy", O_Busy, 1'b0);
        check("rst_err", O_Err, 2'b00);
        check("rst_state", state_dbg, 2'd0);
        reset = 0;

        // Thread of three words with continuous ack.
        I_Ack_Exe = 1;
        drive(1, 32'h3, 4'd5);
        drive(1, w3[0], 0);
        check("s1_a_valid", O_Req_Exe, 1'b1);
        check("s1_a_visible", O_Instr_Exe, w3[0]);
        drive(1, w3[1], 0);
        drive(1, w3[2], 0);
        idle(1);
        pulse_end();
        wait_commits(1, 10, "s1_commit_cnt");
        check("s1_commit_no", last_cno, 4'd5);
        check("s1_deliv_cnt", deliv_q.size(), 3);
        for (int i = 0; i < 3; i++) check("s1_word", deliv_q[i], w3[i]);
        idle(2);
        check("s1_idle_busy", O_Busy, 1'b0);

        // Zero-length thread.
        deliv_q.delete(); e0 = exe_cnt; c0 = commit_cnt;
        drive(1, 32'h0, 4'd9);
        check("s2_early_pulse", O_Req_Commit, 1'b0);
        check("s2_busy", O_Busy, 1'b1);
        drive(0, 0, 0);
        check("s2_pulse", O_Req_Commit, 1'b1);
        check("s2_no", O_CommitNo, 4'd9);
        drive(0, 0, 0);
        check("s2_pulse_done", O_Req_Commit, 1'b0);
        check("s2_busy_done", O_Busy, 1'b0);
        check("s2_no_hold", O_CommitNo, 4'd9);
        check("s2_no_exe", exe_cnt, e0);
        check("s2_commit_cnt", commit_cnt, c0 + 1);

        // Overflow: 18 words with the sequencer stalled.
        deliv_q.delete(); c0 = commit_cnt;
        I_Ack_Exe = 0;
        drive(1, 32'd18, 4'd10);
        for (int i = 0; i < 18; i++) begin
            drive(1, 32'hD000_0000 + i, 0);
            if (i == 15) check("s3_err_before", O_Err[0], 1'b0);
            if (i == 16) check("s3_err_on_17", O_Err[0], 1'b1);
        end
        I_Req = 0; I_Ack_Exe = 1;
        for (int i = 0; i < 40 && O_Req_Exe; i++) @(negedge clock);
        idle(2);
        check("s3_deliv_cnt", deliv_q.size(), 16);
        for (int i = 0; i < 16; i++) check("s3_word", deliv_q[i], 32'hD000_0000 + i);
        check("s3_no_commit_yet", commit_cnt, c0);
        pulse_end();
        wait_commits(c0 + 1, 10, "s3_commit_cnt");
        check("s3_commit_no", last_cno, 4'd10);
        idle(2);

        // Early end pulse retained; extra header during drain.
        do_reset();
        deliv_q.delete(); c0 = commit_cnt;
        drive(1, 32'h2, 4'd7);
        drive(1, 32'h1111_0001, 0);
        drive(1, 32'h2222_0002, 0);
        I_Req = 0; I_Ack_Exe = 1;
        @(negedge clock);
        I_Ack_Exe = 0;
        pulse_end();
        check("s4_y_pending", O_Instr_Exe, 32'h2222_0002);
        check("s4_err_clear", O_Err[0], 1'b0);
        drive(1, 32'h5, 4'd11);
        check("s4_hdr_err", O_Err[0], 1'b1);
        I_Req = 0; I_Ack_Exe = 1;
        wait_commits(c0 + 1, 10, "s4_commit_cnt");
        check("s4_commit_no", last_cno, 4'd7);
        idle(6);
        check("s4_single_commit", commit_cnt, c0 + 1);
        check("s4_deliv_cnt", deliv_q.size(), 2);
        check("s4_word1", deliv_q[1], 32'h2222_0002);

        // Issue-number sequence with wrap-around.
        do_reset();
        c0 = commit_cnt;
        I_Ack_Exe = 1;
        drive(1, 0, 4'd14); idle(4);
        drive(1, 0, 4'd15); idle(4);
        drive(1, 0, 4'd0);  idle(4);
        check("s5_wrap_ok", O_Err[1], 1'b0);
        drive(1, 0, 4'd2);  idle(4);
        check("s5_seq_err", O_Err[1], SEQ_EN);
        check("s5_commits", commit_cnt, c0 + 4);
        check("s5_last_no", last_cno, 4'd2);

        // Reset in the middle of a thread.
        do_reset();
        I_Ack_Exe = 0; c0 = commit_cnt;
        drive(1, 32'h6, 4'd3);
        for (int i = 0; i < 4; i++) drive(1, 32'hE000_0000 + i, 0);
        I_Req = 0;
        check("s6_buffered", O_Instr_Exe, 32'hE000_0000);
        #2 reset = 1;
        #1;
        check("s6_rst_exe", O_Req_Exe, 1'b0);
        check("s6_rst_instr", O_Instr_Exe, 32'h0);
        check("s6_rst_busy", O_Busy, 1'b0);
        check("s6_rst_commit", O_Req_Commit, 1'b0);
        check("s6_rst_state", state_dbg, 2'd0);
        @(negedge clock);
        reset = 0;
        idle(4);
        check("s6_no_commit", commit_cnt, c0);
        deliv_q.delete();
        I_Ack_Exe = 1;
        drive(1, 32'h1, 4'd4);
        drive(1, 32'hF00D_0001, 0);
        idle(2);
        pulse_end();
        wait_commits(c0 + 1, 10, "s6_commit_cnt");
        check("s6_commit_no", last_cno, 4'd4);
        check("s6_deliv", deliv_q.size(), 1);
        check("s6_word", deliv_q[0], 32'hF00D_0001);
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
